// File: rtl/tail_light_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tail_light_pkg
// Description : Shared constants for the tail-light lamp interface: blink
//               sequence, decoded mode codes, side class codes, tracker
//               state codes and the seven-segment digit table.
// Revision    : 1.0 - initial release
// ============================================================================
package tail_light_pkg;

    // Blink sequence, inner lamp first: 000 -> 001 -> 011 -> 111 -> 000
    localparam logic [2:0] c_SEQ0 = 3'b000;
    localparam logic [2:0] c_SEQ1 = 3'b001;
    localparam logic [2:0] c_SEQ2 = 3'b011;
    localparam logic [2:0] c_SEQ3 = 3'b111;

    // Decoded mode codes
    localparam logic [2:0] c_MODE_IDLE        = 3'd0;
    localparam logic [2:0] c_MODE_LEFT        = 3'd1;
    localparam logic [2:0] c_MODE_RIGHT       = 3'd2;
    localparam logic [2:0] c_MODE_HAZARD      = 3'd3;
    localparam logic [2:0] c_MODE_BRAKE       = 3'd4;
    localparam logic [2:0] c_MODE_LEFT_BRAKE  = 3'd5;
    localparam logic [2:0] c_MODE_RIGHT_BRAKE = 3'd6;
    localparam logic [2:0] c_MODE_UNKNOWN     = 3'd7;

    // Per-side classification
    localparam logic [1:0] c_CLS_OFF     = 2'd0;
    localparam logic [1:0] c_CLS_BLINK   = 2'd1;
    localparam logic [1:0] c_CLS_STEADY  = 2'd2;
    localparam logic [1:0] c_CLS_UNKNOWN = 2'd3;

    // Side tracker state encoding
    localparam logic [1:0] c_ST_ACQ       = 2'd0;
    localparam logic [1:0] c_ST_BLINK     = 2'd1;
    localparam logic [1:0] c_ST_STEADY_ON = 2'd2;
    localparam logic [1:0] c_ST_OFF       = 2'd3;

    // Successor of a legal pattern in the blink sequence
    function automatic logic [2:0] seq_next(input logic [2:0] p);
        case (p)
            c_SEQ0:  seq_next = c_SEQ1;
            c_SEQ1:  seq_next = c_SEQ2;
            c_SEQ2:  seq_next = c_SEQ3;
            default: seq_next = c_SEQ0;
        endcase
    endfunction

    // Position of a legal pattern within the sequence
    function automatic logic [1:0] seq_phase(input logic [2:0] p);
        case (p)
            c_SEQ1:  seq_phase = 2'd1;
            c_SEQ2:  seq_phase = 2'd2;
            c_SEQ3:  seq_phase = 2'd3;
            default: seq_phase = 2'd0;
        endcase
    endfunction

    // Only the four sequence patterns can ever appear on a healthy side
    function automatic logic seq_legal(input logic [2:0] p);
        seq_legal = (p == c_SEQ0) || (p == c_SEQ1) || (p == c_SEQ2) || (p == c_SEQ3);
    endfunction

    // Active-low segments gfedcba for digits 0..7
    function automatic logic [6:0] seg7_digit(input logic [2:0] d);
        case (d)
            3'd0:    seg7_digit = 7'h40;
            3'd1:    seg7_digit = 7'h79;
            3'd2:    seg7_digit = 7'h24;
            3'd3:    seg7_digit = 7'h30;
            3'd4:    seg7_digit = 7'h19;
            3'd5:    seg7_digit = 7'h12;
            3'd6:    seg7_digit = 7'h02;
            default: seg7_digit = 7'h78;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/tail_light_side_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tail_light_side_tracker
// Description : Follows one side's three lamp lines, checks the blink
//               sequence and classifies the side as OFF, BLINK, STEADY or
//               UNKNOWN. Flags illegal patterns and skipped steps.
// Revision    : 1.0 - initial release
// ============================================================================
module tail_light_side_tracker
    import tail_light_pkg::*;
#(
    parameter int HOLD_MAX     = 2,
    parameter int STEADY_TICKS = 4,
    parameter int LOCK_STEPS   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_sample_en,
    input  logic [2:0] i_lamps,
    output logic [1:0] o_side_class,
    output logic [1:0] o_phase,
    output logic       o_seq_err
);

    localparam int c_HOLD_W = $clog2(STEADY_TICKS + 1);
    localparam int c_LOCK_W = $clog2(LOCK_STEPS + 1);

    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(HOLD_MAX);
    localparam logic [c_HOLD_W-1:0] c_STEADY   = c_HOLD_W'(STEADY_TICKS);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE = c_HOLD_W'(1);
    localparam logic [c_LOCK_W-1:0] c_LOCK_MAX = c_LOCK_W'(LOCK_STEPS);
    localparam logic [c_LOCK_W-1:0] c_LOCK_ONE = c_LOCK_W'(1);

    logic [1:0]          r_state;
    logic [2:0]          r_prev;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_LOCK_W-1:0] r_lock;

    logic [1:0]          w_state;
    logic [2:0]          w_prev;
    logic [c_HOLD_W-1:0] w_hold;
    logic [c_LOCK_W-1:0] w_lock;
    logic [c_HOLD_W-1:0] w_hold_inc;
    logic [c_LOCK_W-1:0] w_lock_inc;
    logic                w_err;

    // State register; hold count 0 in ACQ means no reference pattern yet
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= c_ST_ACQ;
            r_prev  <= c_SEQ0;
            r_hold  <= '0;
            r_lock  <= '0;
        end else begin
            r_state <= w_state;
            r_prev  <= w_prev;
            r_hold  <= w_hold;
            r_lock  <= w_lock;
        end
    end

    // Next-state: advance / hold / steady detection / error recovery
    always_comb begin
        w_state    = r_state;
        w_prev     = r_prev;
        w_hold     = r_hold;
        w_lock     = r_lock;
        w_err      = 1'b0;
        w_hold_inc = (r_hold == c_STEADY)   ? r_hold : r_hold + c_HOLD_ONE;
        w_lock_inc = (r_lock == c_LOCK_MAX) ? r_lock : r_lock + c_LOCK_ONE;

        if (i_sample_en) begin
            if (!seq_legal(i_lamps)) begin
                w_err = 1'b1;
            end else begin
                case (r_state)
                    c_ST_OFF: begin
                        if (i_lamps == c_SEQ0) begin
                            w_hold = w_hold_inc;
                        end else if (i_lamps == c_SEQ1) begin
                            // First step out of OFF already counts as one advance
                            w_state = c_ST_ACQ;
                            w_prev  = c_SEQ1;
                            w_hold  = c_HOLD_ONE;
                            w_lock  = c_LOCK_ONE;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                    c_ST_STEADY_ON: begin
                        if (i_lamps == c_SEQ3) begin
                            w_hold = w_hold_inc;
                        end else if (i_lamps == c_SEQ0) begin
                            w_state = c_ST_ACQ;
                            w_prev  = c_SEQ0;
                            w_hold  = c_HOLD_ONE;
                            w_lock  = c_LOCK_ONE;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                    default: begin
                        if (r_hold == '0) begin
                            w_prev = i_lamps;
                            w_hold = c_HOLD_ONE;
                            w_lock = '0;
                        end else if (i_lamps == seq_next(r_prev)) begin
                            w_prev = i_lamps;
                            w_hold = c_HOLD_ONE;
                            w_lock = w_lock_inc;
                            if (w_lock_inc == c_LOCK_MAX) begin
                                w_state = c_ST_BLINK;
                            end
                        end else if (i_lamps == r_prev) begin
                            w_hold = w_hold_inc;
                            if (w_hold_inc > c_HOLD_MAX) begin
                                if ((i_lamps == c_SEQ1) || (i_lamps == c_SEQ2)) begin
                                    w_err = 1'b1;
                                end else begin
                                    // Long 000/111: no longer a blink, maybe going steady
                                    w_lock  = '0;
                                    w_state = c_ST_ACQ;
                                    if (w_hold_inc == c_STEADY) begin
                                        w_state = (i_lamps == c_SEQ3) ? c_ST_STEADY_ON : c_ST_OFF;
                                    end
                                end
                            end
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                endcase
            end

            if (w_err) begin
                w_state = c_ST_ACQ;
                w_prev  = c_SEQ0;
                w_hold  = '0;
                w_lock  = '0;
            end
        end
    end

    // Class and phase follow the registered state
    always_comb begin
        case (r_state)
            c_ST_OFF:       o_side_class = c_CLS_OFF;
            c_ST_BLINK:     o_side_class = c_CLS_BLINK;
            c_ST_STEADY_ON: o_side_class = c_CLS_STEADY;
            default:        o_side_class = c_CLS_UNKNOWN;
        endcase
        o_phase   = seq_phase(r_prev);
        o_seq_err = w_err;
    end

endmodule
`default_nettype wire

// File: rtl/tail_light_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tail_light_decoder
// Description : Receiving end of the tail-light lamp interface. Tracks both
//               sides, decodes the driver's intent into a mode code and shows
//               it on one active-low seven-segment digit.
// Revision    : 1.0 - initial release
// ============================================================================
module tail_light_decoder
    import tail_light_pkg::*;
#(
    parameter int HOLD_MAX     = 2,
    parameter int STEADY_TICKS = 4,
    parameter int LOCK_STEPS   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sample_en,
    input  logic [2:0] lamps_left,
    input  logic [2:0] lamps_right,
    output logic [2:0] mode,
    output logic       mode_valid,
    output logic       seq_error,
    output logic [7:0] hex
);

    logic [1:0] w_cls_left;
    logic [1:0] w_cls_right;
    logic [1:0] w_phase_left;
    logic [1:0] w_phase_right;
    logic       w_err_left;
    logic       w_err_right;
    logic [2:0] w_mode;
    logic [7:0] w_hex;

    logic [2:0] r_mode;
    logic       r_mode_valid;
    logic       r_seq_error;
    logic       r_sticky;

    tail_light_side_tracker #(
        .HOLD_MAX     (HOLD_MAX),
        .STEADY_TICKS (STEADY_TICKS),
        .LOCK_STEPS   (LOCK_STEPS)
    ) u_left (
        .clock        (clock),
        .reset        (reset),
        .i_sample_en  (sample_en),
        .i_lamps      (lamps_left),
        .o_side_class (w_cls_left),
        .o_phase      (w_phase_left),
        .o_seq_err    (w_err_left)
    );

    tail_light_side_tracker #(
        .HOLD_MAX     (HOLD_MAX),
        .STEADY_TICKS (STEADY_TICKS),
        .LOCK_STEPS   (LOCK_STEPS)
    ) u_right (
        .clock        (clock),
        .reset        (reset),
        .i_sample_en  (sample_en),
        .i_lamps      (lamps_right),
        .o_side_class (w_cls_right),
        .o_phase      (w_phase_right),
        .o_seq_err    (w_err_right)
    );

    // Combination table: (left class, right class) -> mode
    always_comb begin
        w_mode = c_MODE_UNKNOWN;
        if (w_cls_left == c_CLS_OFF && w_cls_right == c_CLS_OFF) begin
            w_mode = c_MODE_IDLE;
        end else if (w_cls_left == c_CLS_BLINK && w_cls_right == c_CLS_OFF) begin
            w_mode = c_MODE_LEFT;
        end else if (w_cls_left == c_CLS_OFF && w_cls_right == c_CLS_BLINK) begin
            w_mode = c_MODE_RIGHT;
        end else if (w_cls_left == c_CLS_BLINK && w_cls_right == c_CLS_BLINK) begin
            // Sides blinking out of step are not a hazard indication
            if (w_phase_left == w_phase_right) begin
                w_mode = c_MODE_HAZARD;
            end
        end else if (w_cls_left == c_CLS_STEADY && w_cls_right == c_CLS_STEADY) begin
            w_mode = c_MODE_BRAKE;
        end else if (w_cls_left == c_CLS_BLINK && w_cls_right == c_CLS_STEADY) begin
            w_mode = c_MODE_LEFT_BRAKE;
        end else if (w_cls_left == c_CLS_STEADY && w_cls_right == c_CLS_BLINK) begin
            w_mode = c_MODE_RIGHT_BRAKE;
        end
    end

    // Output registers; both sides erroring together still give one pulse
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_mode       <= c_MODE_IDLE;
            r_mode_valid <= 1'b0;
            r_seq_error  <= 1'b0;
            r_sticky     <= 1'b0;
        end else begin
            r_mode       <= w_mode;
            r_mode_valid <= (w_mode != c_MODE_UNKNOWN);
            r_seq_error  <= w_err_left | w_err_right;
            r_sticky     <= r_sticky | w_err_left | w_err_right;
        end
    end

    // Digit blanked when the mode is not legal; decimal point marks a past error
    always_comb begin
        w_hex = {~r_sticky, 7'h7F};
        if (r_mode_valid) begin
            w_hex[6:0] = seg7_digit(r_mode);
        end
    end

    assign mode       = r_mode;
    assign mode_valid = r_mode_valid;
    assign seq_error  = r_seq_error;
    assign hex        = w_hex;

endmodule
`default_nettype wire

// File: tb/tb_tail_light_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tail_light_decoder
// Description : Self-checking bench for tail_light_decoder with a behavioural
//               side model and a per-cycle output compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tail_light_decoder;

    localparam int HOLD   = 2;
    localparam int STEADY = 4;
    localparam int LOCK   = 4;

    // Model side states and classes (bench-local numbering)
    localparam int M_ACQ = 0, M_BLINK = 1, M_ON = 2, M_OFF = 3;
    localparam int K_OFF = 0, K_BLINK = 1, K_STEADY = 2, K_UNK = 3;

    logic       clock;
    logic       reset;
    logic       sample_en;
    logic [2:0] lamps_left;
    logic [2:0] lamps_right;
    logic [2:0] mode;
    logic       mode_valid;
    logic       seq_error;
    logic [7:0] hex;

    tail_light_decoder #(
        .HOLD_MAX     (HOLD),
        .STEADY_TICKS (STEADY),
        .LOCK_STEPS   (LOCK)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sample_en   (sample_en),
        .lamps_left  (lamps_left),
        .lamps_right (lamps_right),
        .mode        (mode),
        .mode_valid  (mode_valid),
        .seq_error   (seq_error),
        .hex         (hex)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [2:0] seqp    [4] = '{3'b000, 3'b001, 3'b011, 3'b111};
    logic [7:0] hex_tab [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

    int s_st [2];
    int s_last [2];
    int s_run [2];
    int s_adv [2];

    logic [2:0] exp_mode;
    logic       exp_valid;
    logic       exp_seq;
    logic       exp_sticky;
    logic [7:0] exp_hex;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_on      = 0;

    function automatic int lidx(input logic [2:0] p);
        case (p)
            3'b000:  return 0;
            3'b001:  return 1;
            3'b011:  return 2;
            3'b111:  return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int side_class(input int st);
        case (st)
            M_BLINK: return K_BLINK;
            M_ON:    return K_STEADY;
            M_OFF:   return K_OFF;
            default: return K_UNK;
        endcase
    endfunction

    function automatic logic [2:0] combine(input int cl, input int cr, input int pl, input int pr);
        if (cl == K_OFF    && cr == K_OFF)                return 3'd0;
        if (cl == K_BLINK  && cr == K_OFF)                return 3'd1;
        if (cl == K_OFF    && cr == K_BLINK)              return 3'd2;
        if (cl == K_BLINK  && cr == K_BLINK && pl == pr)  return 3'd3;
        if (cl == K_STEADY && cr == K_STEADY)             return 3'd4;
        if (cl == K_BLINK  && cr == K_STEADY)             return 3'd5;
        if (cl == K_STEADY && cr == K_BLINK)              return 3'd6;
        return 3'd7;
    endfunction

    task automatic side_clear(input int s);
        s_st[s] = M_ACQ; s_last[s] = -1; s_run[s] = 0; s_adv[s] = 0;
    endtask

    task automatic side_step(input int s, input logic [2:0] p, output bit err);
        int ix;
        ix  = lidx(p);
        err = 0;
        if (ix < 0) begin
            err = 1;
        end else if (s_st[s] == M_OFF) begin
            if (ix == 0) s_run[s]++;
            else if (ix == 1) begin s_st[s] = M_ACQ; s_last[s] = 1; s_run[s] = 1; s_adv[s] = 1; end
            else err = 1;
        end else if (s_st[s] == M_ON) begin
            if (ix == 3) s_run[s]++;
            else if (ix == 0) begin s_st[s] = M_ACQ; s_last[s] = 0; s_run[s] = 1; s_adv[s] = 1; end
            else err = 1;
        end else if (s_last[s] < 0) begin
            s_last[s] = ix; s_run[s] = 1; s_adv[s] = 0;
        end else if (ix == (s_last[s] + 1) % 4) begin
            s_last[s] = ix; s_run[s] = 1; s_adv[s]++;
            if (s_adv[s] >= LOCK) s_st[s] = M_BLINK;
        end else if (ix == s_last[s]) begin
            s_run[s]++;
            if (s_run[s] > HOLD) begin
                if (ix == 1 || ix == 2) err = 1;
                else begin
                    s_adv[s] = 0;
                    s_st[s]  = M_ACQ;
                    if (s_run[s] >= STEADY) s_st[s] = (ix == 3) ? M_ON : M_OFF;
                end
            end
        end else begin
            err = 1;
        end
        if (err) side_clear(s);
    endtask

    // Advance the model by one rising edge
    task automatic model_edge(input logic rn, input logic en, input logic [2:0] l, input logic [2:0] r);
        bit el, er;
        int pl, pr;
        el = 0; er = 0;
        if (!rn) begin
            exp_mode = 3'd0; exp_valid = 1'b0; exp_seq = 1'b0; exp_sticky = 1'b0;
            side_clear(0); side_clear(1);
        end else begin
            pl = (s_last[0] < 0) ? 0 : s_last[0];
            pr = (s_last[1] < 0) ? 0 : s_last[1];
            exp_mode  = combine(side_class(s_st[0]), side_class(s_st[1]), pl, pr);
            exp_valid = (exp_mode != 3'd7);
            if (en) begin
                side_step(0, l, el);
                side_step(1, r, er);
            end
            exp_seq    = el | er;
            exp_sticky = exp_sticky | el | er;
        end
        exp_hex = exp_valid ? hex_tab[exp_mode] : 8'hFF;
        if (exp_sticky) exp_hex[7] = 1'b0;
    endtask

    task automatic tick(input logic rn, input logic en, input logic [2:0] l, input logic [2:0] r);
        reset = rn; sample_en = en; lamps_left = l; lamps_right = r;
        @(posedge clock);
        model_edge(rn, en, l, r);
        @(negedge clock);
    endtask

    task automatic lit(input string name, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %02h, required %02h", name, got, want);
        end
    endtask

    // Per-cycle compare of every output against the model
    always @(negedge clock) begin
        if (chk_on) begin
            vectors++;
            if (mode !== exp_mode || mode_valid !== exp_valid || seq_error !== exp_seq || hex !== exp_hex) begin
                miscompares++;
                $display("FAIL cycle_check t=%0t: mode=%0d valid=%0b seq_error=%0b hex=%02h, required mode=%0d valid=%0b seq_error=%0b hex=%02h",
                         $time, mode, mode_valid, seq_error, hex, exp_mode, exp_valid, exp_seq, exp_hex);
            end
        end
    end

    initial begin
        int gl, gr, couple;
        logic [2:0] pl, pr;
        reset = 1'b0; sample_en = 1'b0; lamps_left = 3'b000; lamps_right = 3'b000;
        side_clear(0); side_clear(1);

        tick(0, 0, 3'b000, 3'b000);
        chk_on = 1;
        tick(0, 0, 3'b000, 3'b000);
        lit("reset_mode", {5'd0, mode}, 8'd0);
        lit("reset_hex", hex, 8'hFF);

        // Idle: both sides dark for the steady window
        repeat (4) tick(1, 1, 3'b000, 3'b000);
        tick(1, 0, 3'b000, 3'b000);
        lit("idle_mode", {5'd0, mode}, 8'd0);
        lit("idle_valid", {7'd0, mode_valid}, 8'd1);
        lit("idle_hex", hex, 8'hC0);
        lit("model_idle", {5'd0, exp_mode}, 8'd0);

        // Left blinking, one sample per step, then two samples per step
        for (int k = 0; k < 8; k++) tick(1, 1, seqp[(k + 1) % 4], 3'b000);
        tick(1, 0, 3'b000, 3'b000);
        lit("left_mode", {5'd0, mode}, 8'd1);
        lit("left_hex", hex, 8'hF9);
        for (int k = 8; k < 16; k++) begin
            tick(1, 1, seqp[(k + 1) % 4], 3'b000);
            tick(1, 1, seqp[(k + 1) % 4], 3'b000);
        end
        tick(1, 0, 3'b000, 3'b000);
        lit("left_slow_mode", {5'd0, mode}, 8'd1);

        // Hazard in phase, then sides out of phase
        tick(0, 0, 3'b000, 3'b000);
        for (int k = 0; k < 10; k++) tick(1, 1, seqp[k % 4], seqp[k % 4]);
        tick(1, 0, 3'b000, 3'b000);
        lit("hazard_mode", {5'd0, mode}, 8'd3);
        lit("hazard_hex", hex, 8'hB0);
        lit("model_hazard", {5'd0, exp_mode}, 8'd3);
        tick(0, 0, 3'b000, 3'b000);
        for (int k = 0; k < 10; k++) tick(1, 1, seqp[k % 4], seqp[(k + 3) % 4]);
        tick(1, 0, 3'b000, 3'b000);
        lit("skew_mode", {5'd0, mode}, 8'd7);
        lit("skew_valid", {7'd0, mode_valid}, 8'd0);
        lit("skew_hex", hex, 8'hFF);

        // Turn with brake on each side, then plain brake
        tick(0, 0, 3'b000, 3'b000);
        for (int k = 0; k < 10; k++) tick(1, 1, seqp[k % 4], 3'b111);
        tick(1, 0, 3'b000, 3'b000);
        lit("lbrake_mode", {5'd0, mode}, 8'd5);
        lit("lbrake_hex", hex, 8'h92);
        tick(0, 0, 3'b000, 3'b000);
        for (int k = 0; k < 10; k++) tick(1, 1, 3'b111, seqp[k % 4]);
        tick(1, 0, 3'b000, 3'b000);
        lit("rbrake_mode", {5'd0, mode}, 8'd6);
        tick(0, 0, 3'b000, 3'b000);
        repeat (4) tick(1, 1, 3'b111, 3'b111);
        tick(1, 0, 3'b000, 3'b000);
        lit("brake_mode", {5'd0, mode}, 8'd4);
        lit("brake_hex", hex, 8'h99);

        // Errors: skipped step, illegal pattern, both sides at once
        tick(0, 0, 3'b000, 3'b000);
        tick(1, 1, 3'b000, 3'b000);
        tick(1, 1, 3'b001, 3'b000);
        tick(1, 1, 3'b111, 3'b000);
        lit("skip_err", {7'd0, seq_error}, 8'd1);
        tick(1, 0, 3'b000, 3'b000);
        lit("skip_err_end", {7'd0, seq_error}, 8'd0);
        lit("sticky_dp", {7'd0, hex[7]}, 8'd0);
        tick(1, 1, 3'b010, 3'b000);
        lit("illegal_err", {7'd0, seq_error}, 8'd1);
        tick(1, 0, 3'b000, 3'b000);
        tick(1, 1, 3'b010, 3'b100);
        lit("dual_err", {7'd0, seq_error}, 8'd1);
        tick(1, 0, 3'b000, 3'b000);
        lit("dual_err_end", {7'd0, seq_error}, 8'd0);

        // Reset during LEFT, then acquisition must start from scratch
        tick(0, 0, 3'b000, 3'b000);
        for (int k = 0; k < 8; k++) tick(1, 1, seqp[k % 4], 3'b000);
        tick(1, 0, 3'b000, 3'b000);
        lit("pre_reset_mode", {5'd0, mode}, 8'd1);
        tick(0, 0, 3'b000, 3'b000);
        lit("mid_reset_mode", {5'd0, mode}, 8'd0);
        lit("mid_reset_valid", {7'd0, mode_valid}, 8'd0);
        lit("mid_reset_hex", hex, 8'hFF);
        for (int k = 1; k < 5; k++) tick(1, 1, seqp[k % 4], 3'b000);
        tick(1, 0, 3'b000, 3'b000);
        lit("reacq_mode", {5'd0, mode}, 8'd7);
        tick(1, 1, 3'b001, 3'b000);
        tick(1, 0, 3'b000, 3'b000);
        lit("relock_mode", {5'd0, mode}, 8'd1);

        // Randomized traffic with occasional coupling, glitches and resets
        gl = 0; gr = 0; couple = 0;
        for (int c = 0; c < 4000; c++) begin
            int r;
            if (c % 200 == 0) couple = $urandom_range(0, 1);
            r = $urandom_range(0, 99);
            if (r < 45) gl = (gl + 1) % 4;
            else if (r >= 85 && r < 92) gl = $urandom_range(0, 3);
            pl = (r < 97) ? seqp[gl] : 3'($urandom_range(0, 7));
            r = $urandom_range(0, 99);
            if (r < 45) gr = (gr + 1) % 4;
            else if (r >= 85 && r < 92) gr = $urandom_range(0, 3);
            pr = (r < 97) ? seqp[gr] : 3'($urandom_range(0, 7));
            if (couple != 0) pr = pl;
            tick(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0), pl, pr);
        end

        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tail_light_decoder.md
Name: tail_light_decoder

Overview:
- Receiving end of the tail-light lamp interface. Samples the six lamp lines (left lamps, right lamps) that the tail-light controller drives.
- Tracks each side's sequential blink pattern and classifies the driver's intent: idle, left, right, hazard, brake, or a turn combined with a brake.
- Shows the decoded mode on one seven-segment digit.
- Used as a loop-back checker on the board and as the self-checking monitor in the tail-light benches.

Parameters:
- HOLD_MAX, 2: maximum consecutive samples one pattern may persist while still counting as a blink step.
- STEADY_TICKS, 4: consecutive samples of 3'b111 (or 3'b000) needed to declare a side steady-on (or off). Must be greater than HOLD_MAX.
- LOCK_STEPS, 4: consecutive legal sequence advances needed to declare a side blinking.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low; all state cleared on a clock edge while low.
- sample_en  in  1  one-clock strobe; lamps are evaluated only on clocks where it is high.
- lamps_left  in  3  left lamps; bit0 is the inner lamp (LEDR[7] position).
- lamps_right  in  3  right lamps; bit0 is the inner lamp.
- mode  out  3  decoded mode code.
- mode_valid  out  1  mode is a legal combination.
- seq_error  out  1  one-clock pulse on an illegal lamp pattern or transition, on either side.
- hex  out  8  active-low segments; bit7 is the decimal point.

Behaviour:
- Reset values: mode=0, mode_valid=0, seq_error=0, hex=8'hFF, error-sticky flag cleared. Both side trackers go to ACQ with all counters at 0.
- Legal blink sequence per side: 000 -> 001 -> 011 -> 111 -> 000.
- Patterns 010, 100, 101 and 110 are always illegal.
- Per-side tracker states and transitions, evaluated only on sample_en:
  - ACQ: entered from reset or after any error. Holding counter tracks repeats of the current pattern.
  - BLINK: entered after LOCK_STEPS consecutive legal advances.
  - STEADY_ON: entered after 111 is held for STEADY_TICKS samples.
  - OFF: entered after 000 is held for STEADY_TICKS samples.
- Advance rule: the next pattern in the sequence increments the lock count and resets the hold count to 1. The same pattern increments the hold count.
- Hold count above HOLD_MAX:
  - On 001 or 011: error.
  - On 000 or 111: lock count clears and the side shows class UNKNOWN until it reaches OFF or STEADY_ON.
- Leaving OFF: 001 restarts acquisition with lock count 1.
- Leaving STEADY_ON: 000 restarts acquisition with lock count 1.
- Any other change out of OFF or STEADY_ON is an error.
- Error response: illegal pattern or skipped step -> seq_error pulses, the side returns to ACQ with counters 0, and the sticky error flag sets.
- Side class per side: OFF, BLINK, STEADY, or UNKNOWN (ACQ or partial hold).
- Each tracker also exports its phase (0..3, position in the sequence).
- Combination table (left class, right class -> mode):
  - OFF, OFF -> 0 IDLE
  - BLINK, OFF -> 1 LEFT
  - OFF, BLINK -> 2 RIGHT
  - BLINK, BLINK with equal phase -> 3 HAZARD
  - STEADY, STEADY -> 4 BRAKE
  - BLINK, STEADY -> 5 LEFT_BRAKE
  - STEADY, BLINK -> 6 RIGHT_BRAKE
  - anything else -> 7, with mode_valid=0
- Update timing: mode and mode_valid are registered and update on the clock after the sample that changed a side's class. Latency is 1 clock from that sample.
- Simultaneous errors: if both sides error on the same sample, seq_error is a single pulse.
- Reset mid-sequence discards all progress; nothing is carried over.
- hex: digit 0-7 of mode, active-low; all segments off when mode_valid=0. Decimal point is lit (bit7=0) while the sticky error flag is set.
- No arithmetic overflow is allowed:
  - Hold counters saturate at STEADY_TICKS.
  - Lock counters saturate at LOCK_STEPS.
  - Widths are $clog2(param+1).

Decomposition:
- Shared package tail_light_pkg holds:
  - mode codes (IDLE..UNKNOWN),
  - side class codes,
  - the sequence constants (SEQ0..SEQ3),
  - the seven-segment digit table.
- The controller side should also import the sequence constants from this package.
- One sub-module, tail_light_side_tracker, is instantiated twice. It holds the per-side state machine, counters, class and phase outputs, and an error pulse.
- The top level holds the combination table, output registers, sticky flag and hex encode.

Test Plan:
- Reset then 000/000 for 4 samples -> mode=0, mode_valid=1, hex=8'hC0.
- Left 000,001,011,111,000,... with 1 sample per step and right 000 -> after the 4th advance, next clock mode=1 and mode_valid=1. Same test with 2 samples per step -> still mode=1.
- Both sides stepping in phase -> mode=3. Right side delayed by one step -> mode=7, mode_valid=0, hex=8'hFF.
- Left blinking, right 111 for 4 samples -> mode=5. Swap sides -> mode=6. Both 111 for 4 samples -> mode=4.
- Left jumps 001 -> 111 -> seq_error pulses exactly 1 clock, left tracker goes to ACQ, hex bit7=0. Left 010 -> error. Both sides erroring on the same sample -> one pulse.
- reset low for 1 clock during mode=1 -> next clock all outputs are at reset values. Acquisition restarts from lock count 0.
